// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor
//   Streaming error-metric accumulator for approximate adders. Each accepted
//   sample (operands plus approximate sum) is compared against the exact sum.
//   Over a run of n_samples it accumulates the error count, the saturating sum
//   of absolute errors and the worst-case error with its operands.
//
// Ports
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        begin a run (accepted only in IDLE/DONE)
//   n_samples    run length, latched on an accepted start
//   in_valid     sample valid
//   in_ready     monitor can accept a sample
//   in_a, in_b   operands fed to the approximate adder
//   in_approx    approximate adder output (WIDTH+1 bits)
//   busy         run in progress (RUN or DRAIN)
//   done         results valid, held until the next accepted start
//   err_count    samples whose approximate sum differs from the exact sum
//   sum_abs_err  saturating sum of absolute errors
//   max_abs_err  largest absolute error seen
//   wce_a/wce_b  operands of the first sample that reached max_abs_err
module approx_adder_err_monitor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err,
  output logic [WIDTH-1:0] wce_a,
  output logic [WIDTH-1:0] wce_b
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] accepted_q;
  logic             start_ok;
  logic             xfer;

  // Stage 1 signals
  logic [WIDTH:0]   exact;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   abs_err;
  logic             s1_valid_q;
  logic [WIDTH:0]   s1_abs_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2 / result registers
  logic [CNT_W-1:0] err_count_q;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W:0]   sum_ext;
  logic [WIDTH:0]   max_q;
  logic [WIDTH-1:0] wce_a_q;
  logic [WIDTH-1:0] wce_b_q;

  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign in_ready = (state_q == StRun) && (accepted_q < n_q);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  // Exact sum keeps the carry; the difference is taken in WIDTH+2 bits two's complement.
  assign exact = {1'b0, in_a} + {1'b0, in_b};
  assign diff  = {1'b0, in_approx} - {1'b0, exact};

  // |diff| never exceeds 2^(WIDTH+1)-1, so negating only the low WIDTH+1 bits is exact.
  always_comb begin
    abs_err = diff[WIDTH:0];
    if (diff[WIDTH+1]) begin
      abs_err = (~diff[WIDTH:0]) + (WIDTH+1)'(1);
    end
  end

  // Carry out of the widened add means the accumulator would overflow.
  assign sum_ext = {1'b0, sum_q} + {{(ACC_W-WIDTH){1'b0}}, s1_abs_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accepted_q == n_q) state_d = StDrain;
      StDrain: if (!s1_valid_q) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Run control: latched length and accepted-sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      accepted_q <= '0;
    end else if (start_ok) begin
      n_q        <= n_samples;
      accepted_q <= '0;
    end else if (xfer) begin
      accepted_q <= accepted_q + CNT_W'(1);
    end
  end

  // Stage 1: register absolute error and operands of each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_abs_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= xfer && !start_ok;
      if (xfer) begin
        s1_abs_q <= abs_err;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
      end
    end
  end

  // Stage 2: fold the registered sample into the run results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      wce_a_q     <= '0;
      wce_b_q     <= '0;
    end else if (start_ok) begin
      err_count_q <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      wce_a_q     <= '0;
      wce_b_q     <= '0;
    end else if (s1_valid_q) begin
      if (s1_abs_q != '0) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
      if (sum_ext[ACC_W]) begin
        sum_q <= '1;
      end else begin
        sum_q <= sum_ext[ACC_W-1:0];
      end
      // Strict compare: ties keep the earliest worst-case sample.
      if (s1_abs_q > max_q) begin
        max_q   <= s1_abs_q;
        wce_a_q <= s1_a_q;
        wce_b_q <= s1_b_q;
      end
    end
  end

  assign err_count   = err_count_q;
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;
  assign wce_a       = wce_a_q;
  assign wce_b       = wce_b_q;

endmodule
